// File: rtl/icebus_pkg.sv
// ---------------------------------------------------------------------------
// icebus_pkg : shared constants, enums and CRC-8 helper for the ICEbus responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package icebus_pkg;

   localparam logic [7:0] SYNC_CMD     = 8'hA5;
   localparam logic [7:0] SYNC_REPLY   = 8'h5A;
   localparam logic [7:0] BROADCAST_ID = 8'hFF;

   typedef enum logic [2:0] {
      REG_SETPOINT     = 3'd0,
      REG_CONTROL_MODE = 3'd1,
      REG_KP           = 3'd2,
      REG_KI           = 3'd3,
      REG_KD           = 3'd4,
      REG_PWM_LIMIT    = 3'd5,
      REG_ENCODER      = 3'd6,
      REG_CURRENT      = 3'd7
   } reg_idx_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ID    = 3'd1,
      ST_CMD   = 3'd2,
      ST_DATA  = 3'd3,
      ST_CRC   = 3'd4,
      ST_EXEC  = 3'd5,
      ST_REPLY = 3'd6
   } state_e;

   // CRC-8, polynomial x^8+x^2+x+1, MSB first, no reflection
   function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/icebus_uart.sv
// ---------------------------------------------------------------------------
// icebus_uart : 8N1 byte receiver (2-flop sync, mid-bit sampling) and transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icebus_uart #(
   parameter int CLKS_PER_BIT = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   input  logic       rx_en_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_err_o,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_o,
   output logic       tx_busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e     rx_state_q;
   logic [1:0]    rx_sync_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic          w_rx_s;

   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic [8:0]    tx_shift_q;

   assign w_rx_s = rx_sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync_q  <= 2'b11;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         rx_err_o   <= 1'b0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], rx_i};
         rx_valid_o <= 1'b0;
         rx_err_o   <= 1'b0;
         if (!rx_en_i) begin
            rx_state_q <= RX_IDLE;
         end else begin
            case (rx_state_q)
               RX_IDLE: begin
                  rx_cnt_q <= '0;
                  if (!w_rx_s) rx_state_q <= RX_START;
               end
               RX_START: begin
                  if (rx_cnt_q == HALF) begin
                     rx_cnt_q   <= '0;
                     rx_bit_q   <= '0;
                     rx_state_q <= w_rx_s ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + 1'b1;
                  end
               end
               RX_DATA: begin
                  if (rx_cnt_q == LAST) begin
                     rx_cnt_q   <= '0;
                     rx_shift_q <= {w_rx_s, rx_shift_q[7:1]};
                     rx_bit_q   <= rx_bit_q + 1'b1;
                     if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + 1'b1;
                  end
               end
               default: begin
                  if (rx_cnt_q == LAST) begin
                     rx_state_q <= RX_IDLE;
                     rx_data_o  <= rx_shift_q;
                     rx_valid_o <= w_rx_s;
                     rx_err_o   <= !w_rx_s;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Shift register holds d0..d7 then the stop bit; start bit is driven on load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_o       <= 1'b1;
         tx_busy_o  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else if (!tx_busy_o) begin
         if (tx_start_i) begin
            tx_o       <= 1'b0;
            tx_busy_o  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, tx_data_i};
         end
      end else if (tx_cnt_q == LAST) begin
         tx_cnt_q <= '0;
         if (tx_bit_q == 4'd9) begin
            tx_o      <= 1'b1;
            tx_busy_o <= 1'b0;
         end else begin
            tx_o       <= tx_shift_q[0];
            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            tx_bit_q   <= tx_bit_q + 1'b1;
         end
      end else begin
         tx_cnt_q <= tx_cnt_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/icebus_responder.sv
// ---------------------------------------------------------------------------
// icebus_responder : ICEbus frame FSM and register bank (CRC-8 with ICEBUS_RESPONDER_CRC_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icebus_responder #(
   parameter int CLKS_PER_BIT = 25,
   parameter int TIMEOUT_CLKS = 2000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   output logic               tx,
   input  logic [7:0]         my_id,
   input  logic signed [31:0] encoder_position,
   input  logic signed [15:0] current,
   output logic [31:0]        setpoint,
   output logic [7:0]         control_mode,
   output logic [15:0]        Kp,
   output logic [15:0]        Ki,
   output logic [15:0]        Kd,
   output logic [23:0]        pwm_limit,
   output logic               cmd_strobe,
   output logic [15:0]        crc_error_count
);
   import icebus_pkg::*;

   localparam int GW = $clog2(TIMEOUT_CLKS + 1);
   localparam int WW = $clog2(CLKS_PER_BIT) + 1;

   state_e        state_q;
   logic [7:0]    id_q, cmd_q, crc_q, reply_crc_q, tx_byte_q;
   logic [31:0]   data_q, reply_val_q;
   logic [1:0]    byte_cnt_q;
   logic [GW-1:0] gap_q;
   logic [WW-1:0] wait_q;
   logic [3:0]    tx_idx_q;
   logic          tx_start_q;

   logic [7:0]    w_rx_data;
   logic          w_rx_valid, w_rx_err, w_tx_busy, w_addressed, w_crc_bad, w_wr_rw;
   logic [31:0]   w_cur_val, w_new_val;
   logic [7:0]    w_reply_byte;
   reg_idx_e      w_sel;

   icebus_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk       (clk),
      .reset     (reset),
      .rx_i      (rx),
      .rx_en_i   (state_q != ST_REPLY),
      .rx_data_o (w_rx_data),
      .rx_valid_o(w_rx_valid),
      .rx_err_o  (w_rx_err),
      .tx_start_i(tx_start_q),
      .tx_data_i (tx_byte_q),
      .tx_o      (tx),
      .tx_busy_o (w_tx_busy)
   );

   assign w_sel       = reg_idx_e'(cmd_q[2:0]);
   assign w_addressed = (id_q == my_id) || (id_q == BROADCAST_ID);
   assign w_wr_rw     = cmd_q[7] && (cmd_q[2:1] != 2'b11);
`ifdef ICEBUS_RESPONDER_CRC_EN
   assign w_crc_bad   = (w_rx_data != crc_q);
`else
   assign w_crc_bad   = 1'b0;
`endif

   // Value of the selected register as it will read after EXEC
   always_comb begin
      w_cur_val = setpoint;
      case (w_sel)
         REG_CONTROL_MODE: w_cur_val = {24'd0, control_mode};
         REG_KP:           w_cur_val = {16'd0, Kp};
         REG_KI:           w_cur_val = {16'd0, Ki};
         REG_KD:           w_cur_val = {16'd0, Kd};
         REG_PWM_LIMIT:    w_cur_val = {8'd0, pwm_limit};
         REG_ENCODER:      w_cur_val = encoder_position;
         REG_CURRENT:      w_cur_val = {{16{current[15]}}, current};
         default:          w_cur_val = setpoint;
      endcase
      w_new_val = w_cur_val;
      if (w_wr_rw) begin
         case (w_sel)
            REG_CONTROL_MODE: w_new_val = {24'd0, data_q[7:0]};
            REG_KP, REG_KI, REG_KD: w_new_val = {16'd0, data_q[15:0]};
            REG_PWM_LIMIT:    w_new_val = {8'd0, data_q[23:0]};
            default:          w_new_val = data_q;
         endcase
      end
   end

   always_comb begin
      w_reply_byte = 8'h00;
      case (tx_idx_q)
         4'd0: w_reply_byte = SYNC_REPLY;
         4'd1: w_reply_byte = my_id;
         4'd2: w_reply_byte = cmd_q;
         4'd3: w_reply_byte = reply_val_q[7:0];
         4'd4: w_reply_byte = reply_val_q[15:8];
         4'd5: w_reply_byte = reply_val_q[23:16];
         4'd6: w_reply_byte = reply_val_q[31:24];
`ifdef ICEBUS_RESPONDER_CRC_EN
         4'd7: w_reply_byte = reply_crc_q;
`endif
         default: w_reply_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         id_q            <= '0;
         cmd_q           <= '0;
         crc_q           <= '0;
         data_q          <= '0;
         byte_cnt_q      <= '0;
         gap_q           <= '0;
         wait_q          <= '0;
         tx_idx_q        <= '0;
         tx_start_q      <= 1'b0;
         tx_byte_q       <= '0;
         reply_val_q     <= '0;
         reply_crc_q     <= '0;
         setpoint        <= 32'd0;
         control_mode    <= 8'd0;
         Kp              <= 16'd1;
         Ki              <= 16'd0;
         Kd              <= 16'd0;
         pwm_limit       <= 24'd500;
         cmd_strobe      <= 1'b0;
         crc_error_count <= 16'd0;
      end else begin
         cmd_strobe <= 1'b0;
         tx_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_rx_valid && (w_rx_data == SYNC_CMD)) begin
                  state_q <= ST_ID;
                  gap_q   <= '0;
                  crc_q   <= '0;
               end
            end
            ST_ID, ST_CMD, ST_DATA, ST_CRC: begin
               if (w_rx_err) begin
                  state_q <= ST_IDLE;
               end else if (w_rx_valid) begin
                  gap_q <= '0;
                  crc_q <= crc8(crc_q, w_rx_data);
                  case (state_q)
                     ST_ID: begin
                        id_q    <= w_rx_data;
                        state_q <= ST_CMD;
                     end
                     ST_CMD: begin
                        cmd_q      <= w_rx_data;
                        byte_cnt_q <= '0;
                        state_q    <= ST_DATA;
                     end
                     ST_DATA: begin
                        data_q     <= {w_rx_data, data_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 2'd3) state_q <= ST_CRC;
                     end
                     default: begin
                        if (!w_addressed) begin
                           state_q <= ST_IDLE;
                        end else if (w_crc_bad) begin
                           state_q <= ST_IDLE;
                           if (crc_error_count != 16'hFFFF)
                              crc_error_count <= crc_error_count + 1'b1;
                        end else begin
                           state_q <= ST_EXEC;
                        end
                     end
                  endcase
               end else if (gap_q == GW'(TIMEOUT_CLKS - 1)) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            ST_EXEC: begin
               if (w_wr_rw) begin
                  cmd_strobe <= 1'b1;
                  case (w_sel)
                     REG_SETPOINT:     setpoint     <= data_q;
                     REG_CONTROL_MODE: control_mode <= data_q[7:0];
                     REG_KP:           Kp           <= data_q[15:0];
                     REG_KI:           Ki           <= data_q[15:0];
                     REG_KD:           Kd           <= data_q[15:0];
                     default:          pwm_limit    <= data_q[23:0];
                  endcase
               end
               reply_val_q <= w_new_val;
               reply_crc_q <= '0;
               tx_idx_q    <= '0;
               wait_q      <= WW'(CLKS_PER_BIT - 2);
               state_q     <= (id_q == my_id) ? ST_REPLY : ST_IDLE;
            end
            ST_REPLY: begin
               // One bit-time of turnaround, then bytes back-to-back as TX frees up
               if (wait_q != '0) begin
                  wait_q <= wait_q - 1'b1;
               end else if (!w_tx_busy && !tx_start_q) begin
                  if (tx_idx_q == 4'd8) begin
                     state_q <= ST_IDLE;
                  end else begin
                     tx_start_q <= 1'b1;
                     tx_byte_q  <= w_reply_byte;
                     tx_idx_q   <= tx_idx_q + 1'b1;
                     if ((tx_idx_q >= 4'd1) && (tx_idx_q <= 4'd6))
                        reply_crc_q <= crc8(reply_crc_q, w_reply_byte);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
